// File: rtl/pbkdf2_pkg.sv
// Shared constants and state encoding for the PBKDF2-HMAC-SHA256 iteration controller.
package pbkdf2_pkg;

   localparam int KEY_W  = 512;
   localparam int SALT_W = 224;
   localparam int DIG_W  = 256;
   localparam int MSG_W  = 1024;

   localparam logic [KEY_W-1:0] IPAD512 = {64{8'h36}};
   localparam logic [KEY_W-1:0] OPAD512 = {64{8'h5c}};
   // Every HMAC message is 96 bytes, so the tail padding is a fixed constant.
   localparam logic [DIG_W-1:0] PAD768  = {8'h80, 184'h0, 64'd768};

   typedef enum logic [2:0] {
      IDLE,
      INNER_REQ,
      INNER_WAIT,
      OUTER_REQ,
      OUTER_WAIT,
      DONE
   } state_t;

endpackage

// File: rtl/hmac_block_fmt.sv
// Assembles one 1024-bit HMAC hasher message: padded key, 256-bit payload, fixed tail.
module hmac_block_fmt
   import pbkdf2_pkg::*;
(
   input  logic [KEY_W-1:0] key,
   input  logic [DIG_W-1:0] msg256,
   input  logic             sel_outer,
   output logic [MSG_W-1:0] block
);

   assign block = {key ^ (sel_outer ? OPAD512 : IPAD512), msg256, PAD768};

endmodule

// File: rtl/pbkdf2_iter_ctrl.sv
// PBKDF2-HMAC-SHA256 iteration controller: sequences c inner/outer HMAC calls
// through sha256_1024in and XOR-accumulates the U values into T.
module pbkdf2_iter_ctrl
   import pbkdf2_pkg::*;
#(
   parameter int ITER_W = 20
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [KEY_W-1:0]   key_i,
   input  logic [SALT_W-1:0]  salt_i,
   input  logic [31:0]        blk_idx_i,
   input  logic [ITER_W-1:0]  iter_i,
   input  logic               start_valid_i,
   output logic               start_ready_o,
   output logic [MSG_W-1:0]   hash_in_o,
   output logic               hash_in_valid_o,
   input  logic               hash_in_ready_i,
   input  logic [DIG_W-1:0]   hash_out_i,
   input  logic               hash_out_valid_i,
   output logic               hash_out_ready_o,
   output logic [DIG_W-1:0]   dk_o,
   output logic               dk_valid_o,
   input  logic               dk_ready_i
);

   state_t              state;
   logic [KEY_W-1:0]    key_reg;
   logic [ITER_W-1:0]   iter_reg;
   logic [ITER_W:0]     count;
   logic [DIG_W-1:0]    t_reg;

   logic [KEY_W-1:0]    fmt_key;
   logic [DIG_W-1:0]    fmt_msg;
   logic                fmt_outer;
   logic [MSG_W-1:0]    fmt_block;
   logic [DIG_W-1:0]    t_nxt;
   logic [ITER_W:0]     count_nxt;

   // The next message is built on the edge that enters a REQ state so hash_in_o
   // is a register and stays stable for the whole request.
   assign fmt_key   = (state == IDLE) ? key_i : key_reg;
   assign fmt_msg   = (state == IDLE) ? {salt_i, blk_idx_i} : hash_out_i;
   assign fmt_outer = (state == INNER_WAIT);
   assign t_nxt     = t_reg ^ hash_out_i;
   assign count_nxt = count + (ITER_W+1)'(1);

   hmac_block_fmt u_fmt (
      .key       (fmt_key),
      .msg256    (fmt_msg),
      .sel_outer (fmt_outer),
      .block     (fmt_block)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state            <= IDLE;
         key_reg          <= '0;
         iter_reg         <= '0;
         count            <= '0;
         t_reg            <= '0;
         start_ready_o    <= 1'b1;
         hash_in_o        <= '0;
         hash_in_valid_o  <= 1'b0;
         hash_out_ready_o <= 1'b0;
         dk_o             <= '0;
         dk_valid_o       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid_i && start_ready_o) begin
                  key_reg         <= key_i;
                  iter_reg        <= (iter_i == '0) ? ITER_W'(1) : iter_i;
                  count           <= '0;
                  t_reg           <= '0;
                  hash_in_o       <= fmt_block;
                  hash_in_valid_o <= 1'b1;
                  start_ready_o   <= 1'b0;
                  state           <= INNER_REQ;
               end
            end
            INNER_REQ: begin
               if (hash_in_ready_i) begin
                  hash_in_valid_o  <= 1'b0;
                  hash_out_ready_o <= 1'b1;
                  state            <= INNER_WAIT;
               end
            end
            INNER_WAIT: begin
               if (hash_out_valid_i) begin
                  hash_out_ready_o <= 1'b0;
                  hash_in_o        <= fmt_block;
                  hash_in_valid_o  <= 1'b1;
                  state            <= OUTER_REQ;
               end
            end
            OUTER_REQ: begin
               if (hash_in_ready_i) begin
                  hash_in_valid_o  <= 1'b0;
                  hash_out_ready_o <= 1'b1;
                  state            <= OUTER_WAIT;
               end
            end
            OUTER_WAIT: begin
               if (hash_out_valid_i) begin
                  hash_out_ready_o <= 1'b0;
                  t_reg            <= t_nxt;
                  count            <= count_nxt;
                  // One extra bit on count keeps the compare exact at c = 2^ITER_W-1.
                  if (count_nxt == {1'b0, iter_reg}) begin
                     dk_o       <= t_nxt;
                     dk_valid_o <= 1'b1;
                     state      <= DONE;
                  end else begin
                     hash_in_o       <= fmt_block;
                     hash_in_valid_o <= 1'b1;
                     state           <= INNER_REQ;
                  end
               end
            end
            DONE: begin
               if (dk_ready_i) begin
                  dk_valid_o    <= 1'b0;
                  start_ready_o <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pbkdf2_iter_ctrl.sv
// Scoreboard bench for pbkdf2_iter_ctrl with a behavioural stub hasher whose
// digest is a simple deterministic mixing function of the 1024-bit message.
module tb_pbkdf2_iter_ctrl;

   localparam int ITER_W = 20;

   logic               clk_i = 1'b0;
   logic               rst_i = 1'b1;
   logic [511:0]       key_i = '0;
   logic [223:0]       salt_i = '0;
   logic [31:0]        blk_idx_i = '0;
   logic [ITER_W-1:0]  iter_i = '0;
   logic               start_valid_i = 1'b0;
   logic               start_ready_o;
   logic [1023:0]      hash_in_o;
   logic               hash_in_valid_o;
   logic               hash_in_ready_i = 1'b0;
   logic [255:0]       hash_out_i = '0;
   logic               hash_out_valid_i = 1'b0;
   logic               hash_out_ready_o;
   logic [255:0]       dk_o;
   logic               dk_valid_o;
   logic               dk_ready_i = 1'b0;

   pbkdf2_iter_ctrl #(.ITER_W(ITER_W)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .key_i            (key_i),
      .salt_i           (salt_i),
      .blk_idx_i        (blk_idx_i),
      .iter_i           (iter_i),
      .start_valid_i    (start_valid_i),
      .start_ready_o    (start_ready_o),
      .hash_in_o        (hash_in_o),
      .hash_in_valid_o  (hash_in_valid_o),
      .hash_in_ready_i  (hash_in_ready_i),
      .hash_out_i       (hash_out_i),
      .hash_out_valid_i (hash_out_valid_i),
      .hash_out_ready_o (hash_out_ready_o),
      .dk_o             (dk_o),
      .dk_valid_o       (dk_valid_o),
      .dk_ready_i       (dk_ready_i)
   );

   always #5 clk_i = ~clk_i;

   localparam logic [511:0] TB_IPAD = {64{8'h36}};
   localparam logic [511:0] TB_OPAD = {64{8'h5c}};
   localparam logic [255:0] TB_PAD  = {8'h80, 184'h0, 64'h0000_0000_0000_0300};

   int n_vec = 0;
   int n_bad = 0;
   logic [255:0] exp_q[$];

   bit  stall_en = 0;
   int  in_xfers = 0;
   int  dk_seen = 0;
   int  stab_err = 0;
   bit  p_in_xfer = 0, p_out_xfer = 0;
   logic [1023:0] p_msg = '0;
   bit  prev_in_stall = 0, prev_dk_stall = 0;
   logic [1023:0] prev_hin = '0;
   logic [255:0]  prev_dk = '0;
   bit  s_busy = 0;
   int  s_dly = 0;
   logic [255:0] s_dig = '0;

   function automatic logic [255:0] stub_h(input logic [1023:0] m);
      logic [255:0] a, b, c, d;
      a = m[1023:768]; b = m[767:512]; c = m[511:256]; d = m[255:0];
      return (a + {b[250:0], b[255:251]}) ^ (c * 256'd3) ^ {d[127:0], d[255:128]}
             ^ {8{32'h9e3779b9}};
   endfunction

   function automatic logic [255:0] model_dk(input logic [511:0] key, input logic [223:0] salt,
                                             input logic [31:0] idx, input int iter);
      logic [255:0] msg, ih, u, t;
      int n;
      n = (iter == 0) ? 1 : iter;
      msg = {salt, idx};
      t = '0;
      for (int i = 0; i < n; i++) begin
         ih = stub_h({key ^ TB_IPAD, msg, TB_PAD});
         u  = stub_h({key ^ TB_OPAD, ih, TB_PAD});
         t  = t ^ u;
         msg = u;
      end
      return t;
   endfunction

   function automatic int pick_dly();
      return stall_en ? int'($urandom_range(0, 7)) : 0;
   endfunction

   // Transfer sampling and stability monitoring on the active edge (pre-update values).
   always @(posedge clk_i) begin
      p_in_xfer  = hash_in_valid_o && hash_in_ready_i;
      p_out_xfer = hash_out_valid_i && hash_out_ready_o;
      if (p_in_xfer) begin
         p_msg = hash_in_o;
         in_xfers++;
      end
      if (dk_valid_o) dk_seen++;
      if (rst_i) begin
         prev_in_stall = 0;
         prev_dk_stall = 0;
      end else begin
         if (prev_in_stall && (!hash_in_valid_o || hash_in_o !== prev_hin)) stab_err++;
         if (prev_dk_stall && (!dk_valid_o || dk_o !== prev_dk)) stab_err++;
         prev_in_stall = hash_in_valid_o && !hash_in_ready_i;
         prev_hin      = hash_in_o;
         prev_dk_stall = dk_valid_o && !dk_ready_i;
         prev_dk       = dk_o;
      end
   end

   // Stub hasher, driven on the falling edge.
   always @(negedge clk_i) begin
      if (rst_i) begin
         hash_in_ready_i  = 0;
         hash_out_valid_i = 0;
         hash_out_i       = '0;
         s_busy = 0;
         s_dly  = 0;
      end else begin
         if (p_in_xfer) begin
            hash_in_ready_i = 0;
            s_busy = 1;
            s_dig  = stub_h(p_msg);
            s_dly  = pick_dly();
         end
         if (p_out_xfer) begin
            hash_out_valid_i = 0;
            hash_out_i       = '0;
            s_busy = 0;
            s_dly  = pick_dly();
         end
         if (!s_busy && hash_in_valid_o && !hash_in_ready_i) begin
            if (s_dly == 0) hash_in_ready_i = 1;
            else s_dly--;
         end
         if (s_busy && !hash_out_valid_i) begin
            if (s_dly == 0) begin
               hash_out_valid_i = 1;
               hash_out_i       = s_dig;
            end else s_dly--;
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic start_job(input logic [511:0] key, input logic [223:0] salt,
                            input logic [31:0] idx, input int iter, input bit stall);
      int cyc;
      cyc = 0;
      while (!start_ready_o && cyc < 100) begin
         @(negedge clk_i);
         cyc++;
      end
      n_vec++;
      if (!start_ready_o) begin
         n_bad++;
         $display("FAIL start_ready timeout: got %0b, required 1", start_ready_o);
      end
      stall_en = stall;
      in_xfers = 0;
      key_i = key; salt_i = salt; blk_idx_i = idx; iter_i = ITER_W'(iter);
      start_valid_i = 1;
      exp_q.push_back(model_dk(key, salt, idx, iter));
      @(negedge clk_i);
      start_valid_i = 0;
      key_i = {16{$urandom()}}; salt_i = {7{$urandom()}}; blk_idx_i = $urandom();
      iter_i = ITER_W'($urandom());
   endtask

   task automatic finish_job(input int iter, input int hold);
      int cyc, budget, n;
      logic [255:0] held, expv;
      n = (iter == 0) ? 1 : iter;
      budget = 64 * (n + 1) + 200;
      cyc = 0;
      while (!dk_valid_o && cyc < budget) begin
         @(negedge clk_i);
         cyc++;
      end
      n_vec++;
      if (!dk_valid_o) begin
         n_bad++;
         $display("FAIL dk_valid timeout: got 0 after %0d cycles, required 1", cyc);
         exp_q.delete();
         return;
      end
      held = dk_o;
      repeat (hold) @(negedge clk_i);
      n_vec++;
      if (start_ready_o !== 1'b0) begin
         n_bad++;
         $display("FAIL start_ready in DONE: got %0b, required 0", start_ready_o);
      end
      n_vec++;
      if (dk_o !== held || dk_valid_o !== 1'b1) begin
         n_bad++;
         $display("FAIL dk hold: got %h valid %0b, required %h valid 1", dk_o, dk_valid_o, held);
      end
      expv = exp_q.pop_front();
      n_vec++;
      if (dk_o !== expv) begin
         n_bad++;
         $display("FAIL dk value c=%0d: got %h, required %h", iter, dk_o, expv);
      end
      dk_ready_i = 1;
      @(negedge clk_i);
      dk_ready_i = 0;
      n_vec++;
      if (dk_valid_o !== 1'b0 || start_ready_o !== 1'b1 || dk_o !== expv) begin
         n_bad++;
         $display("FAIL dk release: got valid %0b ready %0b dk %h, required 0 1 %h",
                  dk_valid_o, start_ready_o, dk_o, expv);
      end
      n_vec++;
      if (in_xfers !== 2 * n) begin
         n_bad++;
         $display("FAIL hasher transfers c=%0d: got %0d, required %0d", iter, in_xfers, 2 * n);
      end
   endtask

   logic [511:0] pw_key;
   logic [223:0] salt_seq;

   task automatic test_reset();
      n_vec++;
      if (start_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset start_ready: got %0b, required 1", start_ready_o); end
      n_vec++;
      if (hash_in_valid_o !== 1'b0 || hash_out_ready_o !== 1'b0) begin
         n_bad++; $display("FAIL reset hash handshakes: got %0b %0b, required 0 0", hash_in_valid_o, hash_out_ready_o);
      end
      n_vec++;
      if (dk_valid_o !== 1'b0 || dk_o !== '0) begin
         n_bad++; $display("FAIL reset dk: got valid %0b dk %h, required 0 0", dk_valid_o, dk_o);
      end
      n_vec++;
      if (hash_in_o !== '0) begin n_bad++; $display("FAIL reset hash_in_o: got %h, required 0", hash_in_o); end
   endtask

   task automatic test_iterations();
      start_job(pw_key, salt_seq, 32'd1, 1, 0);    finish_job(1, 0);
      start_job(pw_key, salt_seq, 32'd1, 2, 0);    finish_job(2, 0);
      start_job(pw_key, salt_seq, 32'd1, 0, 0);    finish_job(0, 0);
      start_job(pw_key, salt_seq, 32'd1, 4096, 0); finish_job(4096, 0);
   endtask

   task automatic test_inner_msg();
      int cyc;
      logic [255:0] first_dig;
      start_job('0, salt_seq, 32'd1, 1, 0);
      n_vec++;
      if (hash_in_valid_o !== 1'b1 || hash_in_o[1023:512] !== {64{8'h36}}) begin
         n_bad++; $display("FAIL inner key field: got %h, required 36..36", hash_in_o[1023:512]);
      end
      n_vec++;
      if (hash_in_o[511:256] !== {salt_seq, 32'h0000_0001}) begin
         n_bad++; $display("FAIL inner payload: got %h, required %h", hash_in_o[511:256], {salt_seq, 32'h1});
      end
      n_vec++;
      if (hash_in_o[255:0] !== {8'h80, 184'h0, 64'd768}) begin
         n_bad++; $display("FAIL inner tail: got %h, required 80..0300", hash_in_o[255:0]);
      end
      first_dig = stub_h({{64{8'h36}}, salt_seq, 32'h1, {8'h80, 184'h0, 64'd768}});
      cyc = 0;
      while (!(in_xfers >= 1 && hash_in_valid_o) && cyc < 50) begin
         @(negedge clk_i);
         cyc++;
      end
      n_vec++;
      if (hash_in_valid_o !== 1'b1 || hash_in_o[1023:512] !== {64{8'h5c}}) begin
         n_bad++; $display("FAIL outer key field: got %h, required 5c..5c", hash_in_o[1023:512]);
      end
      n_vec++;
      if (hash_in_o[511:0] !== {first_dig, 8'h80, 184'h0, 64'd768}) begin
         n_bad++; $display("FAIL outer payload: got %h, required %h", hash_in_o[511:0], {first_dig, 8'h80, 184'h0, 64'd768});
      end
      finish_job(1, 0);
   endtask

   task automatic test_stall();
      stab_err = 0;
      start_job({16{32'hc0ffee11}}, salt_seq ^ {7{32'h5555aaaa}}, 32'd2, 5, 1);
      finish_job(5, 10);
      start_job(pw_key, salt_seq, 32'd3, 3, 1);
      finish_job(3, 4);
      n_vec++;
      if (stab_err !== 0) begin n_bad++; $display("FAIL stall stability: got %0d violations, required 0", stab_err); end
   endtask

   task automatic test_ignore_start();
      start_job(pw_key, salt_seq, 32'd7, 6, 0);
      repeat (3) @(negedge clk_i);
      start_valid_i = 1;
      iter_i = ITER_W'(1);
      repeat (2) @(negedge clk_i);
      start_valid_i = 0;
      finish_job(6, 2);
   endtask

   task automatic test_reset_mid_job();
      int cyc, seen0;
      start_job(pw_key, salt_seq, 32'd1, 10, 0);
      cyc = 0;
      while (in_xfers < 6 && cyc < 200) begin
         @(negedge clk_i);
         cyc++;
      end
      n_vec++;
      if (hash_out_ready_o !== 1'b1) begin
         n_bad++; $display("FAIL reach outer wait: got hash_out_ready %0b, required 1", hash_out_ready_o);
      end
      #1 rst_i = 1;
      #1;
      exp_q.delete();
      test_reset();
      seen0 = dk_seen;
      repeat (2) @(negedge clk_i);
      rst_i = 0;
      repeat (20) @(negedge clk_i);
      n_vec++;
      if (dk_seen !== seen0) begin
         n_bad++; $display("FAIL reset dk pulse: got %0d valid cycles, required 0", dk_seen - seen0);
      end
      start_job(pw_key, salt_seq, 32'd1, 10, 0);
      finish_job(10, 0);
   endtask

   task automatic test_back_to_back();
      for (int j = 0; j < 3; j++) begin
         start_job({16{$urandom()}}, {7{$urandom()}}, $urandom(), j + 2, 1);
         finish_job(j + 2, 0);
      end
   endtask

   initial begin
      logic [63:0] pw;
      pw = "password";
      pw_key = {pw, 448'h0};
      for (int i = 0; i < 28; i++) salt_seq[223 - 8*i -: 8] = 8'(i);
      repeat (3) @(negedge clk_i);
      test_reset();
      rst_i = 0;
      @(negedge clk_i);
      test_iterations();
      test_inner_msg();
      test_stall();
      test_ignore_start();
      test_reset_mid_job();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pbkdf2_iter_ctrl.md
Name: pbkdf2_iter_ctrl

Overview:
- Iteration controller for PBKDF2-HMAC-SHA256. It computes one 256-bit derived-key block, T = U1 ^ U2 ^ ... ^ Uc.
- Builds each 1024-bit HMAC message (inner and outer), drives sha256_1024in, and consumes its 256-bit digests.
- Runs the feedback loop c times. Sits directly upstream and downstream of sha256_1024in, and is the only client of that block.

Parameters:
ITER_W, 20, width of iteration count (max c = 2^ITER_W-1)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
key_i  input  512  HMAC key, zero-padded to 64 bytes (keys over 64 bytes are pre-hashed upstream)
salt_i  input  224  28-byte salt
blk_idx_i  input  32  PBKDF2 block index INT(i), big-endian
iter_i  input  ITER_W  iteration count c
start_valid_i  input  1  job request valid
start_ready_o  output  1  controller idle, accepts job
hash_in_o  output  1024  message to hasher
hash_in_valid_o  output  1  hash_in_o valid
hash_in_ready_i  input  1  hasher accepts message
hash_out_i  input  256  digest from hasher
hash_out_valid_i  input  1  digest valid
hash_out_ready_o  output  1  controller accepts digest
dk_o  output  256  derived key block T
dk_valid_o  output  1  dk_o valid
dk_ready_i  input  1  consumer accepts dk_o

Behaviour:
- Handshakes: valid/ready. A transfer happens on the rising clk_i edge when both are high. Payloads are held stable while valid is high and ready is low.
- Reset (asynchronous): state=IDLE; count=0; all registers=0; start_ready_o=1; hash_in_valid_o=0; hash_out_ready_o=0; dk_valid_o=0; dk_o=0; hash_in_o=0. Reset mid-job abandons the job with no partial output. The hasher shares rst_i.
- Message format (big-endian, bit 1023 = first byte): hash_in_o = {key ^ PAD_BYTE, msg256, PAD768}.
  - PAD_BYTE = ipad (0x36 repeated) for inner, opad (0x5c repeated) for outer.
  - PAD768 = {8'h80, 184'h0, 64'd768}.
  - Total message length is 96 bytes, so every call is exactly two SHA blocks.
- State machine:
  - IDLE: start_ready_o=1. On start transfer, latch key, msg_reg={salt_i, blk_idx_i}, iter_reg=(iter_i==0 ? 1 : iter_i), count=0, T=0 -> INNER_REQ.
  - INNER_REQ: hash_in_valid_o=1; message uses ipad and msg_reg. On accept -> INNER_WAIT.
  - INNER_WAIT: hash_out_ready_o=1. On digest, ih_reg=hash_out_i -> OUTER_REQ.
  - OUTER_REQ: hash_in_valid_o=1; message uses opad and ih_reg. On accept -> OUTER_WAIT.
  - OUTER_WAIT: hash_out_ready_o=1. On digest U: T <= T ^ U; msg_reg <= U; count <= count+1. If count+1 == iter_reg -> DONE, else INNER_REQ.
  - DONE: dk_valid_o=1, dk_o=T. On dk_ready_i -> IDLE. start_ready_o rises the next cycle, not in the same cycle.
- Controller latency: 1 cycle per state beyond the hasher stalls. Total time = c × (2 hash calls + 4 cycles) + 2 cycles.
- Boundary conditions:
  - count compare uses ITER_W+1 bits, so there is no wrap at the maximum c.
  - iter_i=0 behaves exactly as c=1.
  - start_valid_i outside IDLE is ignored; inputs are sampled only at start transfer.
  - hash_out_valid_i while the controller is not in a WAIT state is ignored (ready=0).
  - hash_in_ready_i and hash_out_valid_i arriving in the same cycle cannot conflict, because the states are disjoint.
- Arithmetic: XOR only, with no width growth. T after the first iteration equals U1.

Decomposition:
- pbkdf2_pkg holds:
  - IPAD512, OPAD512, PAD768 constants;
  - the state enum (IDLE, INNER_REQ, INNER_WAIT, OUTER_REQ, OUTER_WAIT, DONE);
  - KEY_W=512, SALT_W=224, DIG_W=256, MSG_W=1024.
- Sub-module hmac_block_fmt (combinational): takes key, msg256 and sel_outer, and produces the 1024-bit message. The sequencing stays in pbkdf2_iter_ctrl.

Test Plan:
- Key "password", zero-padded; salt bytes 00..1b; idx=1; c=1; real sha256_1024in attached -> dk_o equals the software model HMAC-SHA256(key, salt||00000001). Exactly 2 hasher input transfers.
- Same inputs with c=2 and c=4096 -> dk_o matches the software PBKDF2 model. Hasher input transfers = 4 and 8192.
- iter_i=0 -> result and transfer count identical to c=1.
- Stub hasher with random in_ready/out_valid stalls (0–7 cycles) and dk_ready_i held low for 10 cycles -> hash_in_o and dk_o remain stable while stalled, and dk_o is unchanged after release.
- Inner-message check with a stub: key=0, first INNER_REQ -> hash_in_o[1023:512] = 0x36 repeated, [511:256] = {salt, 00000001}, [255:0] = PAD768. In OUTER_REQ, bits [1023:512] = 0x5c repeated.
- Assert rst_i during OUTER_WAIT of iteration 3 (c=10) -> outputs return to reset values immediately with no dk_valid_o pulse. A new job after reset gives the correct result.
